datmem_axi_lite_slave: RTL and testbench

- AXI4-Lite responder that owns the data memory as a word-wide byte-strobed SRAM.
- Sits on the far end of the data-memory AXI4-Lite link and serves the core's load/store master.
- Supports one outstanding transaction, independent AW/W acceptance and programmable response wait states, so the master's busy/stall path can be exercised.
- Reports SLVERR for out-of-range addresses.

---
 rtl/datmem_axi_lite_slave.sv | 223 ++++++++++++++++++++++
 tb/tb_datmem_axi_lite_slave.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datmem_axi_lite_slave.sv
// rtl/datmem_axi_lite_slave.sv - AXI4-Lite data-memory responder with byte-strobed word SRAM
//
// Serves the core's load/store master over AXI4-Lite. Owns a DEPTH x 32-bit
// SRAM. Accepts one transaction at a time. AW and W may arrive in either
// order or together. The response can be delayed by WAIT_CYCLES idle cycles.
// Word indices at or above DEPTH get SLVERR. Such writes are dropped, and
// such reads return zero.
//
// Ports:
//   ACLK, ARSTN              clock (rising edge), asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY   write address channel
//   WDATA/WSTRB/WVALID/WREADY write data channel (WSTRB[i] enables byte i)
//   BRESP/BVALID/BREADY      write response channel (00 OKAY, 10 SLVERR)
//   ARADDR/ARVALID/ARREADY   read address channel
//   RDATA/RRESP/RVALID/RREADY read data channel (00 OKAY, 10 SLVERR)
module datmem_axi_lite_slave #(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        ACLK,
    input  logic        ARSTN,
    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,
    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,
    input  logic [31:0] ARADDR,
    input  logic        ARVALID,
    output logic        ARREADY,
    output logic [31:0] RDATA,
    output logic [1:0]  RRESP,
    output logic        RVALID,
    input  logic        RREADY
);

    localparam int unsigned IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WR_COLLECT,
        WR_WAIT,
        WR_RESP,
        RD_WAIT,
        RD_RESP
    } state_t;

    state_t      state;

    // Capture flags for the two write halves; they stay set until the write
    // leaves WR_WAIT so a half cannot be accepted twice.
    logic        aw_done;
    logic        w_done;

    logic [31:0] waddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] raddr_q;
    logic [3:0]  wait_cnt;

    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [DEPTH];

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             aw_have;
    logic             w_have;
    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_commit;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // Ready signals are combinational from state and capture flags. Reads
    // back off whenever any write half is being offered, so writes win ties.
    assign AWREADY = ((state == IDLE) || (state == WR_COLLECT)) && !aw_done;
    assign WREADY  = ((state == IDLE) || (state == WR_COLLECT)) && !w_done;
    assign ARREADY = (state == IDLE) && !AWVALID && !WVALID;

    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign ar_hs   = ARVALID && ARREADY;

    // A half counts as present if captured earlier or handshaking right now.
    assign aw_have = aw_done || aw_hs;
    assign w_have  = w_done || w_hs;

    // Address bits [1:0] are ignored; the word index is addr[31:2].
    assign wr_in_range = (waddr_q >> 2) < DEPTH;
    assign rd_in_range = (raddr_q >> 2) < DEPTH;
    assign wr_idx      = waddr_q[IDX_W+1:2];
    assign rd_idx      = raddr_q[IDX_W+1:2];

    // The commit happens on the same edge that raises BVALID.
    assign wr_commit   = (state == WR_WAIT) && (wait_cnt == 4'd0) && wr_in_range;

    assign BVALID = bvalid_q;
    assign BRESP  = bresp_q;
    assign RVALID = rvalid_q;
    assign RRESP  = rresp_q;
    assign RDATA  = rdata_q;

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            state    <= IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            wait_cnt <= 4'd0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            raddr_q  <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            // Write-half capture is shared by IDLE and WR_COLLECT; the ready
            // rule already blocks it in every other state.
            if (aw_hs) begin
                waddr_q <= AWADDR;
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
                w_done  <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (aw_hs || w_hs) begin
                        if (aw_have && w_have) begin
                            state    <= WR_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= WR_COLLECT;
                        end
                    end else if (ar_hs) begin
                        raddr_q  <= ARADDR;
                        state    <= RD_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end

                WR_COLLECT: begin
                    if (aw_have && w_have) begin
                        state    <= WR_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end
                end

                WR_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state    <= WR_RESP;
                        bvalid_q <= 1'b1;
                        bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                WR_RESP: begin
                    if (BREADY) begin
                        bvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end

                RD_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state    <= RD_RESP;
                        rvalid_q <= 1'b1;
                        rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                        rdata_q  <= rd_in_range ? mem[rd_idx] : 32'h0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                RD_RESP: begin
                    if (RREADY) begin
                        rvalid_q <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory array has no reset; contents survive ARSTN.
    always_ff @(posedge ACLK) begin
        if (wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem[wr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_datmem_axi_lite_slave.sv
// tb/tb_datmem_axi_lite_slave.sv - scoreboard bench for datmem_axi_lite_slave
module tb_datmem_axi_lite_slave;

    localparam int DEPTH = 1024;
    localparam int NDUT  = 2;

    typedef struct {
        bit          is_rd;
        logic [1:0]  resp;
        logic [31:0] data;
        int          hs;
    } exp_t;

    logic        aclk = 1'b0;
    logic        arstn;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0] awaddr [NDUT];
    logic        awvalid[NDUT];
    logic        awready[NDUT];
    logic [31:0] wdata  [NDUT];
    logic [3:0]  wstrb  [NDUT];
    logic        wvalid [NDUT];
    logic        wready [NDUT];
    logic [1:0]  bresp  [NDUT];
    logic        bvalid [NDUT];
    logic        bready [NDUT];
    logic [31:0] araddr [NDUT];
    logic        arvalid[NDUT];
    logic        arready[NDUT];
    logic [31:0] rdata  [NDUT];
    logic [1:0]  rresp  [NDUT];
    logic        rvalid [NDUT];
    logic        rready [NDUT];

    // Reference memory image per DUT, updated in transaction order.
    logic [31:0] mdl [NDUT][DEPTH];
    exp_t        q0[$];
    exp_t        q1[$];

    // Monitor history: previous valid/ready and the held expectation.
    logic        pb [NDUT];
    logic        pbr[NDUT];
    logic        pr [NDUT];
    logic        prr[NDUT];
    logic [1:0]  hb [NDUT];
    logic [1:0]  hr [NDUT];
    logic [31:0] hd [NDUT];

    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    datmem_axi_lite_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .ACLK(aclk), .ARSTN(arstn),
        .AWADDR(awaddr[0]), .AWVALID(awvalid[0]), .AWREADY(awready[0]),
        .WDATA(wdata[0]), .WSTRB(wstrb[0]), .WVALID(wvalid[0]), .WREADY(wready[0]),
        .BRESP(bresp[0]), .BVALID(bvalid[0]), .BREADY(bready[0]),
        .ARADDR(araddr[0]), .ARVALID(arvalid[0]), .ARREADY(arready[0]),
        .RDATA(rdata[0]), .RRESP(rresp[0]), .RVALID(rvalid[0]), .RREADY(rready[0])
    );

    datmem_axi_lite_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
        .ACLK(aclk), .ARSTN(arstn),
        .AWADDR(awaddr[1]), .AWVALID(awvalid[1]), .AWREADY(awready[1]),
        .WDATA(wdata[1]), .WSTRB(wstrb[1]), .WVALID(wvalid[1]), .WREADY(wready[1]),
        .BRESP(bresp[1]), .BVALID(bvalid[1]), .BREADY(bready[1]),
        .ARADDR(araddr[1]), .ARVALID(arvalid[1]), .ARREADY(arready[1]),
        .RDATA(rdata[1]), .RRESP(rresp[1]), .RVALID(rvalid[1]), .RREADY(rready[1])
    );

    function automatic int wt(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h expected %h (t=%0t)", d, name, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic pop(input int d, input bit want_rd, output bit got, output exp_t e);
        got = 1'b0;
        e = '{default: 0};
        if (d == 0) begin
            if (q0.size() > 0 && q0[0].is_rd == want_rd) begin e = q0.pop_front(); got = 1'b1; end
        end else begin
            if (q1.size() > 0 && q1[0].is_rd == want_rd) begin e = q1.pop_front(); got = 1'b1; end
        end
    endtask

    // Reference behaviour: word index addr/4, in range below DEPTH.
    function automatic exp_t model_write(input int d, input logic [31:0] addr, input logic [31:0] data,
                                         input logic [3:0] strb, input int hs);
        exp_t e;
        logic [31:0] idx = addr / 4;
        e.is_rd = 1'b0;
        e.data  = 32'h0;
        e.hs    = hs;
        if (idx < DEPTH) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[d][idx][8*b +: 8] = data[8*b +: 8];
            e.resp = 2'b00;
        end else begin
            e.resp = 2'b10;
        end
        return e;
    endfunction

    function automatic exp_t model_read(input int d, input logic [31:0] addr, input int hs);
        exp_t e;
        logic [31:0] idx = addr / 4;
        e.is_rd = 1'b1;
        e.hs    = hs;
        e.resp  = (idx < DEPTH) ? 2'b00 : 2'b10;
        e.data  = (idx < DEPTH) ? mdl[d][idx] : 32'h0;
        return e;
    endfunction

    // Waits (bounded) for the chosen ready, then lets the handshake edge pass.
    // which: 0 AW+W, 1 AW, 2 W, 3 AR
    task automatic wait_hs(input int d, input int which, output int hs);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge aclk);
            case (which)
                0:       ok = awready[d] && wready[d];
                1:       ok = awready[d];
                2:       ok = wready[d];
                default: ok = arready[d];
            endcase
        end
        check(d, "hs_timeout", 32'(ok), 32'd1);
        hs = cyc;
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_done(input int d, input bit is_rd, input int dly);
        bit seen = 1'b0;
        bit done = 1'b0;
        if (dly > 0) begin
            for (int i = 0; i < 100 && !seen; i++) begin
                @(negedge aclk);
                seen = is_rd ? rvalid[d] : bvalid[d];
            end
            repeat (dly) @(posedge aclk);
            #1;
            if (is_rd) rready[d] = 1'b1;
            else bready[d] = 1'b1;
        end
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge aclk);
            done = is_rd ? (rvalid[d] && rready[d]) : (bvalid[d] && bready[d]);
        end
        check(d, "resp_timeout", 32'(done), 32'd1);
        @(posedge aclk);
        #1;
    endtask

    // gap 0: AW and W together; gap>0: AW first, W gap cycles later; gap<0: W first.
    task automatic write_txn(input int d, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int gap, input int bdly);
        int hs;
        bit aw_first;
        int n;
        if (bdly > 0) bready[d] = 1'b0;
        awaddr[d] = addr;
        wdata[d]  = data;
        wstrb[d]  = strb;
        if (gap == 0) begin
            awvalid[d] = 1'b1;
            wvalid[d]  = 1'b1;
            wait_hs(d, 0, hs);
            awvalid[d] = 1'b0;
            wvalid[d]  = 1'b0;
        end else begin
            aw_first = (gap > 0);
            n = aw_first ? gap : -gap;
            if (aw_first) awvalid[d] = 1'b1;
            else wvalid[d] = 1'b1;
            wait_hs(d, aw_first ? 1 : 2, hs);
            awvalid[d] = 1'b0;
            wvalid[d]  = 1'b0;
            repeat (n - 1) begin
                @(negedge aclk);
                check(d, "collect_awready", 32'(awready[d]), aw_first ? 32'd0 : 32'd1);
                check(d, "collect_wready", 32'(wready[d]), aw_first ? 32'd1 : 32'd0);
                check(d, "collect_arready", 32'(arready[d]), 32'd0);
                @(posedge aclk);
                #1;
            end
            if (aw_first) wvalid[d] = 1'b1;
            else awvalid[d] = 1'b1;
            wait_hs(d, aw_first ? 2 : 1, hs);
            awvalid[d] = 1'b0;
            wvalid[d]  = 1'b0;
        end
        push(d, model_write(d, addr, data, strb, hs));
        wait_done(d, 1'b0, bdly);
    endtask

    task automatic read_txn(input int d, input logic [31:0] addr, input int rdly);
        int hs;
        if (rdly > 0) rready[d] = 1'b0;
        araddr[d]  = addr;
        arvalid[d] = 1'b1;
        wait_hs(d, 3, hs);
        arvalid[d] = 1'b0;
        push(d, model_read(d, addr, hs));
        wait_done(d, 1'b1, rdly);
    endtask

    // AW, W and AR offered together: the write must win and AR waits for B.
    task automatic collide_txn(input int d);
        int hs;
        bit done = 1'b0;
        awaddr[d] = 32'h20;
        wdata[d]  = 32'h55;
        wstrb[d]  = 4'hF;
        araddr[d] = 32'h20;
        awvalid[d] = 1'b1;
        wvalid[d]  = 1'b1;
        arvalid[d] = 1'b1;
        wait_hs(d, 0, hs);
        awvalid[d] = 1'b0;
        wvalid[d]  = 1'b0;
        push(d, model_write(d, 32'h20, 32'h55, 4'hF, hs));
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge aclk);
            check(d, "ar_blocked", 32'(arready[d]), 32'd0);
            done = bvalid[d] && bready[d];
        end
        check(d, "collide_b_timeout", 32'(done), 32'd1);
        @(posedge aclk);
        #1;
        wait_hs(d, 3, hs);
        arvalid[d] = 1'b0;
        push(d, model_read(d, 32'h20, hs));
        wait_done(d, 1'b1, 0);
    endtask

    function automatic logic [31:0] pick_addr();
        int r = int'($urandom_range(0, 9));
        logic [31:0] lo = 32'($urandom_range(0, 3));
        if (r < 7) return 32'($urandom_range(0, 15)) * 4 + lo;
        if (r == 7) return 32'hFFC | lo;
        return 32'h1000 | $urandom;
    endfunction

    task automatic reset_checks(input int d);
        check(d, "rst_bvalid", 32'(bvalid[d]), 32'd0);
        check(d, "rst_rvalid", 32'(rvalid[d]), 32'd0);
        check(d, "rst_bresp", 32'(bresp[d]), 32'd0);
        check(d, "rst_rresp", 32'(rresp[d]), 32'd0);
        check(d, "rst_rdata", rdata[d], 32'd0);
        check(d, "rst_awready", 32'(awready[d]), 32'd1);
        check(d, "rst_wready", 32'(wready[d]), 32'd1);
        check(d, "rst_arready", 32'(arready[d]), 32'd1);
    endtask

    task automatic mon(input int d);
        exp_t e;
        bit got;
        if (!arstn) begin
            pb[d] = 1'b0; pbr[d] = 1'b0; pr[d] = 1'b0; prr[d] = 1'b0;
            return;
        end
        if (pb[d] && pbr[d]) begin
            check(d, "b_clear", 32'(bvalid[d]), 32'd0);
        end else if (pb[d]) begin
            check(d, "b_hold_valid", 32'(bvalid[d]), 32'd1);
            check(d, "b_hold_resp", 32'(bresp[d]), 32'(hb[d]));
        end else if (bvalid[d]) begin
            pop(d, 1'b0, got, e);
            check(d, "b_expected", 32'(got), 32'd1);
            if (got) begin
                check(d, "bresp", 32'(bresp[d]), 32'(e.resp));
                check(d, "b_latency", 32'(cyc - e.hs), 32'(2 + wt(d)));
            end
            hb[d] = e.resp;
        end
        if (pr[d] && prr[d]) begin
            check(d, "r_clear", 32'(rvalid[d]), 32'd0);
        end else if (pr[d]) begin
            check(d, "r_hold_valid", 32'(rvalid[d]), 32'd1);
            check(d, "r_hold_resp", 32'(rresp[d]), 32'(hr[d]));
            check(d, "r_hold_data", rdata[d], hd[d]);
        end else if (rvalid[d]) begin
            pop(d, 1'b1, got, e);
            check(d, "r_expected", 32'(got), 32'd1);
            if (got) begin
                check(d, "rresp", 32'(rresp[d]), 32'(e.resp));
                check(d, "rdata", rdata[d], e.data);
                check(d, "r_latency", 32'(cyc - e.hs), 32'(2 + wt(d)));
            end
            hr[d] = e.resp;
            hd[d] = e.data;
        end
        pb[d]  = bvalid[d];
        pbr[d] = bready[d];
        pr[d]  = rvalid[d];
        prr[d] = rready[d];
    endtask

    initial begin
        forever begin
            @(negedge aclk);
            for (int d = 0; d < NDUT; d++) mon(d);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        arstn = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            awaddr[d] = '0; awvalid[d] = 1'b0; wdata[d] = '0; wstrb[d] = '0; wvalid[d] = 1'b0;
            bready[d] = 1'b1; araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b1;
        end
        repeat (3) @(negedge aclk);
        for (int d = 0; d < NDUT; d++) reset_checks(d);
        @(posedge aclk);
        #1;
        arstn = 1'b1;

        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 16; i++) write_txn(d, 32'(i * 4), $urandom, 4'hF, 0, 0);
            write_txn(d, 32'hFFC, $urandom, 4'hF, 0, 0);

            write_txn(d, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
            read_txn(d, 32'h10, 0);
            write_txn(d, 32'h13, 32'h000000AA, 4'b0001, 0, 0);
            read_txn(d, 32'h10, 0);
            write_txn(d, 32'h14, 32'hCAFEF00D, 4'hF, 3, 4);
            write_txn(d, 32'h18, 32'h0BADF00D, 4'b1010, -2, 2);
            write_txn(d, 32'h1000, 32'h12345678, 4'hF, 0, 0);
            read_txn(d, 32'h1000, 0);
            read_txn(d, 32'h0, 0);
            read_txn(d, 32'hFFC, 3);
            collide_txn(d);

            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 3) < 2)
                    write_txn(d, pick_addr(), $urandom, 4'($urandom), int'($urandom_range(0, 4)) - 2,
                              int'($urandom_range(0, 3)));
                else
                    read_txn(d, pick_addr(), int'($urandom_range(0, 3)));
            end
        end

        // Reset while DUT1 (3 wait cycles) is in RD_WAIT: the read is dropped.
        begin
            int hs;
            araddr[1]  = 32'h10;
            arvalid[1] = 1'b1;
            wait_hs(1, 3, hs);
            arvalid[1] = 1'b0;
            @(posedge aclk);
            #2;
            arstn = 1'b0;
            @(negedge aclk);
            for (int d = 0; d < NDUT; d++) reset_checks(d);
            @(posedge aclk);
            #1;
            arstn = 1'b1;
            repeat (8) @(negedge aclk);
            check(1, "rvalid_after_reset", 32'(rvalid[1]), 32'd0);
            @(posedge aclk);
            #1;
            write_txn(1, 32'h24, 32'hA5A5_1234, 4'hF, 0, 0);
            read_txn(1, 32'h24, 0);
        end

        repeat (4) @(negedge aclk);
        check(0, "q_empty", 32'(q0.size()), 32'd0);
        check(1, "q_empty", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
